// File: rtl/tlk2711_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlk2711_axi_pkg
//  Brief    : AXI response/burst encodings and FSM state types for the
//             tlk2711 AXI memory slave.
//  Revision : 1.0
// ============================================================================
package tlk2711_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_8B = 3'b011;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Response codes are ordered by severity, so the larger code wins.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlk2711_axi_mem_bram.sv
`default_nettype none
// ============================================================================
//  Module   : tlk2711_axi_mem_bram
//  Brief    : Simple dual-port RAM, byte-enable write port and registered
//             read port (read-before-write on address collision).
//  Revision : 1.0
// ============================================================================
module tlk2711_axi_mem_bram #(
   parameter int DEPTH = 4096,
   parameter int DW    = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [DW/8-1:0] i_wbe,
   input  logic [DW-1:0]   i_wdata,
   input  logic            i_re,
   input  logic [AW-1:0]   i_raddr,
   output logic [DW-1:0]   o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < DW/8; b++) begin
            if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/tlk2711_axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tlk2711_axi_mem_slave
//  Brief    : AXI4 slave backed by on-chip RAM; independent read and write
//             channels, one outstanding burst per direction.
//  Revision : 1.0
// ============================================================================
module tlk2711_axi_mem_slave
   import tlk2711_axi_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 48,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    BYTE_WIDTH = 8,
   parameter int                    MEM_DEPTH  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [3:0]            s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [BYTE_WIDTH-1:0] s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [3:0]            s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [3:0]            s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   output logic [3:0]            s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [15:0]           o_err_cnt
);

   localparam int                 c_IDX_W = $clog2(MEM_DEPTH);
   localparam int                 c_WRD_W = ADDR_WIDTH - 2;
   localparam logic [c_WRD_W-1:0] c_DEPTH = c_WRD_W'(MEM_DEPTH);

   // ---------------- write channel ----------------
   wr_state_t            r_wstate;
   logic                 r_awready, r_wready, r_bvalid, r_wfmt_err;
   logic [3:0]           r_wid, r_bid;
   logic [1:0]           r_bresp, r_wacc;
   logic [7:0]           r_wlen;
   logic [8:0]           r_wbeat;
   logic [c_WRD_W-1:0]   r_widx;
   logic [c_WRD_W-1:0]   w_aw_word;
   logic                 w_aw_fmt_err, w_w_fire, w_w_final, w_w_inrange, w_mem_we;
   logic [1:0]           w_w_beat_resp;

   // Extra top bit in the word index keeps beat increments from wrapping.
   assign w_aw_word     = c_WRD_W'((s_axi_awaddr - BASE_ADDR) >> 3);
   assign w_aw_fmt_err  = (s_axi_awsize != SIZE_8B) || (s_axi_awburst != BURST_INCR);
   assign w_w_fire      = r_wready & s_axi_wvalid;
   assign w_w_final     = (r_wbeat == {1'b0, r_wlen});
   assign w_w_inrange   = (r_widx < c_DEPTH);
   assign w_mem_we      = w_w_fire & ~r_wfmt_err & w_w_inrange;
   assign w_w_beat_resp = (r_wfmt_err || (w_w_final != s_axi_wlast)) ? RESP_SLVERR :
                          (!w_w_inrange)                             ? RESP_DECERR : RESP_OKAY;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate   <= W_IDLE;
         r_awready  <= 1'b1;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_bid      <= 4'd0;
         r_wid      <= 4'd0;
         r_wlen     <= 8'd0;
         r_wbeat    <= 9'd0;
         r_widx     <= '0;
         r_wfmt_err <= 1'b0;
         r_wacc     <= RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: if (s_axi_awvalid) begin
               r_wid      <= s_axi_awid;
               r_widx     <= w_aw_word;
               r_wlen     <= s_axi_awlen;
               r_wbeat    <= 9'd0;
               r_wfmt_err <= w_aw_fmt_err;
               r_wacc     <= w_aw_fmt_err ? RESP_SLVERR : RESP_OKAY;
               r_awready  <= 1'b0;
               r_wready   <= 1'b1;
               r_wstate   <= W_DATA;
            end
            W_DATA: if (w_w_fire) begin
               r_wbeat <= r_wbeat + 9'd1;
               r_widx  <= r_widx + 1'b1;
               r_wacc  <= worst_resp(r_wacc, w_w_beat_resp);
               if (w_w_final || s_axi_wlast) begin
                  r_wready <= 1'b0;
                  r_bvalid <= 1'b1;
                  r_bresp  <= worst_resp(r_wacc, w_w_beat_resp);
                  r_bid    <= r_wid;
                  r_wstate <= W_RESP;
               end
            end
            W_RESP: if (s_axi_bready) begin
               r_bvalid  <= 1'b0;
               r_awready <= 1'b1;
               r_wstate  <= W_IDLE;
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // ---------------- read channel ----------------
   rd_state_t            r_rstate;
   logic                 r_arready, r_rvalid, r_rlast, r_rfmt_err, r_rbad, r_rdata_en;
   logic [3:0]           r_rid;
   logic [1:0]           r_rresp;
   logic [7:0]           r_rlen, r_rbeat;
   logic [c_WRD_W-1:0]   r_ridx;
   logic [c_WRD_W-1:0]   w_ar_word, w_rd_idx;
   logic                 w_ar_fmt_err, w_ar_fire, w_r_fire, w_r_more, w_r_done, w_rd_en, w_rd_fmt;
   logic [1:0]           w_rd_resp;
   logic [DATA_WIDTH-1:0] w_ram_q;

   assign w_ar_word    = c_WRD_W'((s_axi_araddr - BASE_ADDR) >> 3);
   assign w_ar_fmt_err = (s_axi_arsize != SIZE_8B) || (s_axi_arburst != BURST_INCR);
   assign w_ar_fire    = r_arready & s_axi_arvalid;
   assign w_r_fire     = r_rvalid & s_axi_rready;
   assign w_r_more     = w_r_fire & (r_rbeat != r_rlen);
   assign w_r_done     = w_r_fire & (r_rbeat == r_rlen);
   // The RAM is addressed with the beat about to be presented, so its
   // registered output lines up with rvalid and stalls hold it for free.
   assign w_rd_en      = w_ar_fire | w_r_more;
   assign w_rd_idx     = w_ar_fire ? w_ar_word : (r_ridx + 1'b1);
   assign w_rd_fmt     = w_ar_fire ? w_ar_fmt_err : r_rfmt_err;
   assign w_rd_resp    = w_rd_fmt ? RESP_SLVERR : (w_rd_idx < c_DEPTH) ? RESP_OKAY : RESP_DECERR;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate   <= R_IDLE;
         r_arready  <= 1'b1;
         r_rvalid   <= 1'b0;
         r_rlast    <= 1'b0;
         r_rid      <= 4'd0;
         r_rresp    <= RESP_OKAY;
         r_rlen     <= 8'd0;
         r_rbeat    <= 8'd0;
         r_ridx     <= '0;
         r_rfmt_err <= 1'b0;
         r_rbad     <= 1'b0;
         r_rdata_en <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: if (w_ar_fire) begin
               r_rid      <= s_axi_arid;
               r_rlen     <= s_axi_arlen;
               r_rbeat    <= 8'd0;
               r_ridx     <= w_rd_idx;
               r_rfmt_err <= w_ar_fmt_err;
               r_rresp    <= w_rd_resp;
               r_rbad     <= (w_rd_resp != RESP_OKAY);
               r_rdata_en <= (w_rd_resp == RESP_OKAY);
               r_rvalid   <= 1'b1;
               r_rlast    <= (s_axi_arlen == 8'd0);
               r_arready  <= 1'b0;
               r_rstate   <= R_DATA;
            end
            R_DATA: begin
               if (w_r_done) begin
                  r_rvalid  <= 1'b0;
                  r_rlast   <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end else if (w_r_more) begin
                  r_rbeat    <= r_rbeat + 8'd1;
                  r_ridx     <= w_rd_idx;
                  r_rresp    <= w_rd_resp;
                  r_rbad     <= r_rbad | (w_rd_resp != RESP_OKAY);
                  r_rdata_en <= (w_rd_resp == RESP_OKAY);
                  r_rlast    <= ((r_rbeat + 8'd1) == r_rlen);
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   tlk2711_axi_mem_bram #(
      .DEPTH (MEM_DEPTH),
      .DW    (DATA_WIDTH),
      .AW    (c_IDX_W)
   ) u_bram (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_widx[c_IDX_W-1:0]),
      .i_wbe   (s_axi_wstrb),
      .i_wdata (s_axi_wdata),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_idx[c_IDX_W-1:0]),
      .o_rdata (w_ram_q)
   );

   // ---------------- error counter ----------------
   logic [15:0] r_err_cnt;
   logic [1:0]  w_err_inc;
   logic [16:0] w_err_sum;

   assign w_err_inc = {1'b0, (r_bvalid & s_axi_bready & (r_bresp != RESP_OKAY))} +
                      {1'b0, (w_r_done & r_rbad)};
   assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

   always_ff @(posedge clk) begin
      if (rst) r_err_cnt <= 16'd0;
      else     r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_bid     = r_bid;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rid     = r_rid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata_en ? w_ram_q : '0;
   assign o_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/tlk2711_axi_mem_slave.md
Name: tlk2711_axi_mem_slave

Overview:
AXI4 memory-mapped responder (slave) backed by on-chip byte-enable RAM. It is the far end of the tlk2711_dma AXI master: it serves the TX read bursts and absorbs the RX write bursts. It is used as the DDR stand-in for loopback bring-up and the block-level bench, and as a scratch buffer in PL-only builds. Read and write channels are fully independent, with one outstanding burst per direction.

Parameters:
ADDR_WIDTH, 48, AXI address width (matches the DMA).
DATA_WIDTH, 64, AXI data width; only 64 is supported.
BYTE_WIDTH, 8, wstrb width, equal to DATA_WIDTH/8.
MEM_DEPTH, 4096, RAM depth in 64-bit words; power of two.
BASE_ADDR, 48'h0, byte address of word 0.

Ports:
clk  in  1  single clock for all channels.
rst  in  1  reset; synchronous, active-high.
s_axi_awvalid/awready  in/out  1/1  write-address handshake.
s_axi_awid  in  4  write ID, echoed on bid.
s_axi_awaddr  in  ADDR_WIDTH  burst start byte address.
s_axi_awlen  in  8  beats minus 1.
s_axi_awsize  in  3  must be 3'b011.
s_axi_awburst  in  2  must be INCR (2'b01).
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  BYTE_WIDTH  byte enables.
s_axi_wlast/wvalid/wready  in/in/out  1  write-data beat control.
s_axi_bid  out  4  echoed awid.
s_axi_bresp  out  2  write response.
s_axi_bvalid/bready  out/in  1  write-response handshake.
s_axi_arvalid/arready  in/out  1  read-address handshake.
s_axi_arid  in  4  read ID.
s_axi_araddr  in  ADDR_WIDTH  read start byte address.
s_axi_arlen  in  8  beats minus 1.
s_axi_arsize  in  3  must be 3'b011.
s_axi_arburst  in  2  must be INCR.
s_axi_rid  out  4  echoed arid.
s_axi_rdata  out  DATA_WIDTH  read data.
s_axi_rresp  out  2  per-beat read response.
s_axi_rlast/rvalid/rready  out/out/in  1  read-data beat control.
o_err_cnt  out  16  count of non-OKAY responses; saturates at 16'hFFFF.

AXI prot, cache and user signals are not ported; the integrator leaves them unconnected.

Behaviour:
Reset values:
- awready=1, arready=1; wready, bvalid, rvalid, rlast = 0.
- bresp, rresp, bid, rid, rdata = 0; o_err_cnt = 0.
- Both FSMs go to IDLE. RAM contents are not reset.

Address rules:
- Word index = ((addr - BASE_ADDR) >> 3) + beat.
- Low 3 address bits are ignored.
- In range means 0 <= addr - BASE_ADDR < MEM_DEPTH*8. Range is checked per beat.
- A burst running past the top gets DECERR on the out-of-range beats. There is no wrap-around.

Error precedence, per burst:
- awsize/arsize != 3 or burst type != INCR -> SLVERR (2'b10) for the whole burst. Writes are suppressed; read data = 0.
- Otherwise, an out-of-range beat -> DECERR (2'b11). That write is suppressed; read data = 0.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On awvalid, latch id, addr, len and the error flag, clear the beat count, go to W_DATA with awready=0.
- W_DATA: wready=1. Each wvalid&wready beat writes RAM bytes where wstrb=1 and increments the beat count.
- The burst ends on the beat where count==len. If wlast disagrees with that (early wlast or missing wlast), bresp=SLVERR.
- Extra beats after an early wlast are not accepted; wready=0 from W_RESP.
- W_RESP: bvalid=1 with the worst response of the burst and bid=latched id. Hold until bready, then return to W_IDLE; awready=1 on the next cycle.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready=1. On the arvalid handshake, register rdata=mem[idx0] and go to R_DATA.
- R_DATA: rvalid=1 from the cycle after AR acceptance, so latency is 1. rlast=1 when beat==len.
- On rvalid&rready with beat<len, rdata loads mem[next] on the same edge, giving zero bubbles under continuous rready.
- With rready low, rdata, rresp and rlast hold stable.
- After the last handshake, go to R_IDLE with rvalid=0.

Simultaneous and boundary cases:
- A read and a write to the same word in the same cycle: the read returns the old data.
- AR and AW arriving in the same cycle are both accepted.
- awlen=0 and arlen=0 give single-beat bursts.
- awlen=255 gives 256 beats; the beat counter is 9 bits.
- o_err_cnt increments once per non-OKAY B response and once per R burst containing any non-OKAY beat.
- rst asserted mid-burst: outputs take reset values on the next edge and the burst is abandoned; already-written words remain.

Decomposition:
- Package tlk2711_axi_pkg holds RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP, SIZE_8B, and the write and read FSM state enums.
- Sub-module tlk2711_axi_mem_bram is a simple dual-port RAM: write port with byte enables, registered read port, MEM_DEPTH x 64, inferable as BRAM.

Test Plan:
- AW addr=BASE+0x40, len=3, then 4 beats of data 0x11..0x44 with wstrb=FF; AR at the same address, len=3 -> bresp=00, bid echoed, rdata 0x11,0x22,0x33,0x44 on consecutive cycles, rlast on the 4th beat.
- Write wstrb=8'h0F of 0xAAAAAAAA_BBBBBBBB over a word holding 0x12345678_9ABCDEF0; read it back -> 0x12345678_BBBBBBBB.
- AR len=255 with rready toggling 1-0-1 -> 256 beats, data held stable while stalled, rlast only on beat 255, no lost or duplicated beats.
- AW at the last word (BASE+(MEM_DEPTH-1)*8) with len=1 -> the first beat is written, bresp=DECERR, o_err_cnt=1; the read-back of the first word matches.
- awburst=FIXED, len=0 -> bresp=SLVERR, RAM unchanged. A wlast on beat 1 of a len=3 burst -> SLVERR, bvalid one cycle after that beat.
- AR and AW accepted in the same cycle to the same word; reset asserted on beat 2 of a len=7 read -> rvalid=0 and arready=1 after the reset edge.
